// File: rtl/matrix_mult_param_if.sv
// Request/status bus of matrix_mult_param: operation request, mode bits and
// operand matrices towards the block, status flags and result matrix back.
interface matrix_mult_param_if #(
   parameter int N  = 4,
   parameter int DW = 16
);
   logic              start;
   logic              acc_mode;
   logic              round_en;
   logic              sat_en;
   logic [N*N*DW-1:0] matrix_a;
   logic [N*N*DW-1:0] matrix_b;
   logic              busy;
   logic              done;
   logic              ovf;
   logic [N*N*DW-1:0] matrix_c;

   modport master (
      output start, acc_mode, round_en, sat_en, matrix_a, matrix_b,
      input  busy, done, ovf, matrix_c
   );

   modport slave (
      input  start, acc_mode, round_en, sat_en, matrix_a, matrix_b,
      output busy, done, ovf, matrix_c
   );
endinterface

// File: rtl/matrix_mult_param.sv
// Signed fixed-point N x N matrix multiplier, C = A*B or C = A*B + C_prev,
// one multiply-accumulate per cycle with per-operation rounding and saturation.
module matrix_mult_param #(
   parameter int N     = 4,
   parameter int DW    = 16,
   parameter int FRAC  = 8,
   parameter int ACC_W = 2*DW + $clog2(N) + 1
) (
   input  logic               clk,
   input  logic               rst,
   matrix_mult_param_if.slave bus
);
   localparam int IW = $clog2(N);
   localparam int MW = N*N*DW;

   localparam logic [IW-1:0]           IDX_ZERO = IW'(0);
   localparam logic [IW-1:0]           IDX_ONE  = IW'(1);
   localparam logic [IW-1:0]           IDX_LAST = IW'(N-1);
   localparam logic [MW-1:0]           MAT_ZERO = {MW{1'b0}};
   localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
   localparam logic signed [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN  = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC-1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_r;
   state_t                  state_next_s;

   logic [MW-1:0]           a_r;
   logic [MW-1:0]           b_r;
   logic [MW-1:0]           c_prev_r;
   logic [MW-1:0]           c_work_r;
   logic [MW-1:0]           c_out_r;
   logic                    acc_mode_r;
   logic                    round_en_r;
   logic                    sat_en_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    ovf_r;
   logic                    ovf_int_r;
   logic [IW-1:0]           row_r;
   logic [IW-1:0]           col_r;
   logic [IW-1:0]           k_r;
   logic signed [ACC_W-1:0] acc_r;

   logic                    accept_s;
   logic                    last_k_s;
   logic                    last_col_s;
   logic                    last_elem_s;
   int                      elem_s;
   logic signed [DW-1:0]    a_sel_s;
   logic signed [DW-1:0]    b_sel_s;
   logic signed [2*DW-1:0]  prod_s;
   logic signed [ACC_W-1:0] acc_next_s;
   logic signed [ACC_W-1:0] acc_reload_s;
   logic [DW:0]             fin_s;

   // Accumulate-mode starting value: C_prev element moved to the product's binary point.
   function automatic logic signed [ACC_W-1:0] preload(input logic [MW-1:0] c, input int idx);
      logic [DW-1:0]           e;
      logic signed [ACC_W-1:0] ext;
      e   = c[idx*DW +: DW];
      ext = {{(ACC_W-DW){e[DW-1]}}, e};
      return ext <<< FRAC;
   endfunction

   // Returns {overflow, element}; out-of-range values clamp or wrap.
   function automatic logic [DW:0] finalise(input logic signed [ACC_W-1:0] v,
                                            input logic rnd, input logic sat);
      logic signed [ACC_W-1:0] s;
      if (rnd) begin
         s = (v + RND_HALF) >>> FRAC;
      end else begin
         s = v >>> FRAC;
      end
      if (s > SAT_MAX) begin
         return sat ? {1'b1, SAT_MAX[DW-1:0]} : {1'b1, s[DW-1:0]};
      end else if (s < SAT_MIN) begin
         return sat ? {1'b1, SAT_MIN[DW-1:0]} : {1'b1, s[DW-1:0]};
      end else begin
         return {1'b0, s[DW-1:0]};
      end
   endfunction

   // Operand selection, MAC and element finalisation for the current (row, col, k).
   always_comb begin
      elem_s      = int'(row_r) * N + int'(col_r);
      a_sel_s     = a_r[(int'(row_r) * N + int'(k_r)) * DW +: DW];
      b_sel_s     = b_r[(int'(k_r) * N + int'(col_r)) * DW +: DW];
      prod_s      = a_sel_s * b_sel_s;
      acc_next_s  = acc_r + {{(ACC_W-2*DW){prod_s[2*DW-1]}}, prod_s};
      fin_s       = finalise(acc_next_s, round_en_r, sat_en_r);
      last_k_s    = (k_r == IDX_LAST);
      last_col_s  = (col_r == IDX_LAST);
      last_elem_s = (row_r == IDX_LAST) && last_col_s;
      if (acc_mode_r && !last_elem_s) begin
         acc_reload_s = preload(c_prev_r, elem_s + 1);
      end else begin
         acc_reload_s = ACC_ZERO;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      accept_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               accept_s     = 1'b1;
               state_next_s = CALC;
            end else begin
               state_next_s = IDLE;
            end
         end
         CALC: begin
            if (last_k_s && last_elem_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = CALC;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Operand capture, index walk, accumulator and result/status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r        <= MAT_ZERO;
         b_r        <= MAT_ZERO;
         c_prev_r   <= MAT_ZERO;
         c_work_r   <= MAT_ZERO;
         c_out_r    <= MAT_ZERO;
         acc_mode_r <= 1'b0;
         round_en_r <= 1'b0;
         sat_en_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ovf_r      <= 1'b0;
         ovf_int_r  <= 1'b0;
         row_r      <= IDX_ZERO;
         col_r      <= IDX_ZERO;
         k_r        <= IDX_ZERO;
         acc_r      <= ACC_ZERO;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_r        <= bus.matrix_a;
                  b_r        <= bus.matrix_b;
                  c_prev_r   <= c_out_r;
                  acc_mode_r <= bus.acc_mode;
                  round_en_r <= bus.round_en;
                  sat_en_r   <= bus.sat_en;
                  busy_r     <= 1'b1;
                  ovf_int_r  <= 1'b0;
                  row_r      <= IDX_ZERO;
                  col_r      <= IDX_ZERO;
                  k_r        <= IDX_ZERO;
                  acc_r      <= bus.acc_mode ? preload(c_out_r, 0) : ACC_ZERO;
               end
            end
            CALC: begin
               if (!last_k_s) begin
                  acc_r <= acc_next_s;
                  k_r   <= k_r + IDX_ONE;
               end else begin
                  c_work_r[elem_s*DW +: DW] <= fin_s[DW-1:0];
                  ovf_int_r <= ovf_int_r | fin_s[DW];
                  acc_r     <= acc_reload_s;
                  k_r       <= IDX_ZERO;
                  if (last_col_s) begin
                     col_r <= IDX_ZERO;
                     row_r <= (row_r == IDX_LAST) ? IDX_ZERO : row_r + IDX_ONE;
                  end else begin
                     col_r <= col_r + IDX_ONE;
                  end
               end
            end
            DONE: begin
               c_out_r <= c_work_r;
               ovf_r   <= ovf_int_r;
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
            end
            default: begin
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.ovf      = ovf_r;
   assign bus.matrix_c = c_out_r;
endmodule
